pixel_stream_writer: RTL and testbench

- Writer end of the pixel RAM interface. It accepts a framed byte stream from the host-side link (SPI/UART receiver) and packs byte pairs into 16-bit pixel words.
- It issues single-cycle write strobes with sequential addresses into pixel_ram's write port. The panel driver reads the other port.
- Each frame is one full RAM image. The block reports frame completion and framing errors.

---
 rtl/pixel_stream_writer.sv | 124 ++++++++++++
 tb/tb_pixel_stream_writer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_writer.sv
// -----------------------------------------------------------------------------
// pixel_stream_writer
//
// Purpose:
//   Writer side of the pixel RAM. Takes a framed byte stream from the host link
//   and packs byte pairs (high byte first) into 16-bit pixel words. Each word is
//   written with a single-cycle strobe at sequential addresses starting at 0.
//   One frame fills WORDS_PER_FRAME words. Completed frames are counted. A
//   start-of-frame arriving mid-frame is flagged as a framing error.
//
// Ports:
//   i_clk            system clock
//   i_reset          synchronous, active-high reset
//   i_byte           stream data byte
//   i_byte_valid     i_byte valid this cycle
//   i_sof            first byte of a frame (qualified by i_byte_valid)
//   o_byte_ready     registered; 0 in reset, then held at 1 (no backpressure)
//   o_ram_addr       write address (holds its value between strobes)
//   o_ram_data       write data    (holds its value between strobes)
//   o_ram_write_stb  one-cycle write enable
//   o_frame_done     one-cycle pulse with the strobe of the last word
//   o_frame_error    one-cycle pulse after a start-of-frame inside a frame
//   o_frame_count    completed frames, wraps 255 -> 0
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | between frames; non-sof bytes are dropped
// HI    | in a frame, next byte is the high byte of the next word
// LO    | in a frame, high byte held, next byte completes the word
// -----------------------------------------------------------------------------
module pixel_stream_writer #(
  parameter int ADDR_WIDTH      = 12,
  parameter int WORDS_PER_FRAME = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  input  logic                  i_sof,
  output logic                  o_byte_ready,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [15:0]           o_ram_data,
  output logic                  o_ram_write_stb,
  output logic                  o_frame_done,
  output logic                  o_frame_error,
  output logic [7:0]            o_frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  // Index of the final word of a frame; reaching it returns the FSM to IDLE,
  // so word_idx never needs to wrap inside a frame.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS_PER_FRAME - 1);

  state_t                state;
  logic [7:0]            high_byte;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;

  assign accept = i_byte_valid && o_byte_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      high_byte       <= 8'd0;
      word_idx        <= '0;
      o_byte_ready    <= 1'b0;
      o_ram_addr      <= '0;
      o_ram_data      <= 16'd0;
      o_ram_write_stb <= 1'b0;
      o_frame_done    <= 1'b0;
      o_frame_error   <= 1'b0;
      o_frame_count   <= 8'd0;
    end else begin
      o_byte_ready    <= 1'b1;
      o_ram_write_stb <= 1'b0;
      o_frame_done    <= 1'b0;
      o_frame_error   <= 1'b0;

      if (accept) begin
        if (i_sof) begin
          // A start-of-frame always (re)starts at word 0; any pending
          // half-word is dropped. Only an interrupted frame is an error.
          o_frame_error <= (state != IDLE);
          high_byte     <= i_byte;
          word_idx      <= '0;
          state         <= LO;
        end else begin
          case (state)
            IDLE: begin
              state <= IDLE;
            end
            HI: begin
              high_byte <= i_byte;
              state     <= LO;
            end
            LO: begin
              o_ram_write_stb <= 1'b1;
              o_ram_addr      <= word_idx;
              o_ram_data      <= {high_byte, i_byte};
              if (word_idx == LAST_IDX) begin
                o_frame_done  <= 1'b1;
                o_frame_count <= o_frame_count + 8'd1;
                word_idx      <= '0;
                state         <= IDLE;
              end else begin
                word_idx <= word_idx + 1'b1;
                state    <= HI;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_writer
//
// Purpose:
//   Self-checking bench for pixel_stream_writer. A reference model tracks the
//   byte position inside the current frame and derives each expected write
//   from that position; every DUT output is compared after every clock.
// -----------------------------------------------------------------------------
module tb_pixel_stream_writer;

  localparam int AW  = 2;
  localparam int WPF = 4;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [7:0]    i_byte;
  logic          i_byte_valid;
  logic          i_sof;
  logic          o_byte_ready;
  logic [AW-1:0] o_ram_addr;
  logic [15:0]   o_ram_data;
  logic          o_ram_write_stb;
  logic          o_frame_done;
  logic          o_frame_error;
  logic [7:0]    o_frame_count;

  always #5 clk = ~clk;

  pixel_stream_writer #(
    .ADDR_WIDTH     (AW),
    .WORDS_PER_FRAME(WPF)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .i_sof          (i_sof),
    .o_byte_ready   (o_byte_ready),
    .o_ram_addr     (o_ram_addr),
    .o_ram_data     (o_ram_data),
    .o_ram_write_stb(o_ram_write_stb),
    .o_frame_done   (o_frame_done),
    .o_frame_error  (o_frame_error),
    .o_frame_count  (o_frame_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pos = bytes received in the current frame, -1 = no frame.
  int          pos = -1;
  logic [7:0]  m_hi = 8'd0;
  logic        exp_ready = 1'b0;
  logic        exp_stb   = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_addr  = 32'd0;
  logic [15:0] exp_data  = 16'd0;
  logic [7:0]  exp_count = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
  endtask

  task automatic model_step(input logic rst, input logic v, input logic s, input logic [7:0] b);
    logic acc;
    acc      = v && exp_ready && !rst;
    exp_stb  = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (rst) begin
      exp_ready = 1'b0;
      exp_addr  = 32'd0;
      exp_data  = 16'd0;
      exp_count = 8'd0;
      pos       = -1;
    end else begin
      exp_ready = 1'b1;
      if (acc) begin
        if (s) begin
          exp_err = (pos >= 0);
          m_hi    = b;
          pos     = 1;
        end else if (pos >= 0) begin
          if (pos % 2 == 0) begin
            m_hi = b;
            pos++;
          end else begin
            exp_stb  = 1'b1;
            exp_addr = 32'(pos / 2);
            exp_data = {m_hi, b};
            pos++;
            if (pos == 2 * WPF) begin
              exp_done  = 1'b1;
              exp_count = exp_count + 8'd1;
              pos       = -1;
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic s, input logic [7:0] b);
    i_reset      = rst;
    i_byte_valid = v;
    i_sof        = s;
    i_byte       = b;
    @(posedge clk);
    model_step(rst, v, s, b);
    #1;
    check("ready", 32'(o_byte_ready),    32'(exp_ready));
    check("stb",   32'(o_ram_write_stb), 32'(exp_stb));
    check("addr",  32'(o_ram_addr),      exp_addr);
    check("data",  32'(o_ram_data),      32'(exp_data));
    check("done",  32'(o_frame_done),    32'(exp_done));
    check("error", 32'(o_frame_error),   32'(exp_err));
    check("count", 32'(o_frame_count),   32'(exp_count));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic s, input logic [7:0] b);
    drive(1'b0, 1'b1, s, b);
  endtask

  // One complete frame; gap_pct is the chance of an idle cycle before each byte.
  task automatic send_frame(input int gap_pct);
    for (int i = 0; i < 2 * WPF; i++) begin
      while ($urandom_range(99) < gap_pct) drive(1'b0, 1'b0, 1'($urandom_range(1)), 8'($urandom));
      send_byte(i == 0, 8'($urandom));
    end
  endtask

  initial begin
    i_reset = 1'b1; i_byte_valid = 1'b0; i_sof = 1'b0; i_byte = 8'h00;

    // Reset values and ready rising one clock after release.
    do_reset(3);

    // Two words of a frame, checked against literal values too.
    send_byte(1'b1, 8'hC0);
    send_byte(1'b0, 8'h00);
    check("t1_data0", 32'(o_ram_data), 32'h0000_C000);
    check("t1_addr0", 32'(o_ram_addr), 32'd0);
    send_byte(1'b1 & 1'b0, 8'h30);
    send_byte(1'b0, 8'h00);
    check("t1_data1", 32'(o_ram_data), 32'h0000_3000);
    check("t1_addr1", 32'(o_ram_addr), 32'd1);
    check("t1_count", 32'(o_frame_count), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Full back-to-back frame after reset.
    do_reset(1);
    send_frame(0);
    check("t2_done_last", 32'(o_frame_done), 32'd1);
    check("t2_addr_last", 32'(o_ram_addr), 32'(WPF - 1));
    check("t2_count", 32'(o_frame_count), 32'd1);
    // Back in IDLE: non-sof bytes must be dropped.
    send_byte(1'b0, 8'hAA);
    send_byte(1'b0, 8'hBB);
    send_byte(1'b0, 8'hCC);
    check("t3_no_stb", 32'(o_ram_write_stb), 32'd0);
    send_frame(0);

    // Framing error: restart mid-frame with a pending high byte.
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h03);
    send_byte(1'b1, 8'h12);
    check("t4_err", 32'(o_frame_error), 32'd1);
    send_byte(1'b0, 8'h34);
    check("t4_err_single", 32'(o_frame_error), 32'd0);
    check("t4_data", 32'(o_ram_data), 32'h0000_1234);
    check("t4_addr", 32'(o_ram_addr), 32'd0);
    for (int i = 0; i < 2 * WPF - 2; i++) send_byte(1'b0, 8'($urandom));
    // Last word completes right before a new sof: no error expected.
    send_frame(0);
    send_frame(0);

    // Reset mid-frame after 5 bytes, with a byte offered during reset and at release.
    send_byte(1'b1, 8'h11);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'($urandom));
    drive(1'b1, 1'b1, 1'b0, 8'h66);
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    drive(1'b0, 1'b1, 1'b1, 8'h55);
    check("t5_ready_after", 32'(o_byte_ready), 32'd1);
    send_byte(1'b0, 8'h99);
    send_frame(0);

    // Gapped stream, 256 frames from reset: frame count wraps back to 0.
    do_reset(1);
    for (int f = 0; f < 256; f++) send_frame(50);
    check("t6_wrap", 32'(o_frame_count), 32'd0);

    // Random stress with occasional sof anywhere.
    for (int i = 0; i < 600; i++)
      drive(1'b0, 1'($urandom_range(3) != 0), 1'($urandom_range(15) == 0), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
